drive_volume_requester: RTL

//  Drive-side initiator of drive_volume_if: turns block read/write requests from the disk-card logic

---
 rtl/drive_req_pkg.sv | 18 +
 rtl/drive_volume_if.sv | 13 +
 rtl/drive_req_watchdog.sv | 20 ++
 rtl/drive_volume_requester.sv | 96 +++++++++
 4 files changed

// File: rtl/drive_req_pkg.sv
// drive_req_pkg: shared status codes, FSM state encodings and limits for drive_volume_requester.
package drive_req_pkg;
   typedef enum logic [2:0] {
      ST_OK          = 3'd0,
      ST_NOT_MOUNTED = 3'd1,
      ST_RANGE       = 3'd2,
      ST_READONLY    = 3'd3,
      ST_TIMEOUT     = 3'd4
   } status_t;
   typedef logic [2:0] state_t;
   localparam state_t IDLE    = 3'd0;
   localparam state_t CHECK   = 3'd1;
   localparam state_t REQ     = 3'd2;
   localparam state_t RELEASE = 3'd3;
   localparam state_t DONE    = 3'd4;
   localparam int MAX_BLK_CNT = 63;
   localparam int BLK_W       = $clog2(MAX_BLK_CNT + 1);
endpackage

// File: rtl/drive_volume_if.sv
// drive_volume_if: block-request handshake between a drive-side requester and PicoSoC firmware.
interface drive_volume_if;
   import drive_req_pkg::*;
   logic             ready, mounted, readonly, ack;
   logic [31:0]      size;
   logic             active, rd, wr;
   logic [31:0]      lba;
   logic [BLK_W-1:0] blk_cnt;
   modport drive (input ready, mounted, readonly, size, ack,
                  output active, lba, blk_cnt, rd, wr);
   modport host (output ready, mounted, readonly, size, ack,
                 input active, lba, blk_cnt, rd, wr);
endinterface

// File: rtl/drive_req_watchdog.sv
// drive_req_watchdog: load-to-zero counter that flags expiry after LIMIT cycles since the last load.
module drive_req_watchdog #(
   parameter int unsigned LIMIT = 1
) (
   input  logic clk,
   input  logic resetn,
   input  logic load,
   output logic expired
);
   localparam int W = LIMIT > 1 ? $clog2(LIMIT) : 1;
   logic [W-1:0] cnt;
   assign expired = cnt == W'(LIMIT - 1);
   always_ff @(posedge clk or negedge resetn)
      if (!resetn)
         cnt <= '0;
      else if (load)
         cnt <= '0;
      else if (!expired)
         cnt <= cnt + 1'b1;
endmodule

// File: rtl/drive_volume_requester.sv
// drive_volume_requester: validates card block requests and runs the rd/wr/ack handshake to firmware.
// Optional per-phase watchdog enabled by defining DRIVE_REQ_TIMEOUT_EN.
module drive_volume_requester
   import drive_req_pkg::*;
#(
   parameter int unsigned CLOCK_SPEED_HZ = 0,
   parameter int unsigned TIMEOUT_MS     = 1000
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             enable,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [31:0]      req_lba,
   input  logic [BLK_W-1:0] req_blk_cnt,
   output logic             done,
   output status_t          status,
   output logic             busy,
   drive_volume_if.drive    volume
);
   state_t           state, state_n;
   status_t          chk_st;
   logic             up, to_flag, expired, accept, lat_write;
   logic [31:0]      lat_lba;
   logic [BLK_W-1:0] lat_cnt;
   // up keeps req_ready low while reset is asserted; a held ack is stale firmware state
   assign req_ready = up && state == IDLE && !volume.ack;
   assign accept    = req_valid && req_ready;
   assign chk_st = (!volume.ready || !volume.mounted) ? ST_NOT_MOUNTED :
                   (lat_cnt == '0 || {1'b0, lat_lba} + 33'(lat_cnt) > {1'b0, volume.size}) ? ST_RANGE :
                   (lat_write && volume.readonly) ? ST_READONLY : ST_OK;
`ifdef DRIVE_REQ_TIMEOUT_EN
   localparam int unsigned LIMIT = CLOCK_SPEED_HZ / 1000 * TIMEOUT_MS;
   if (CLOCK_SPEED_HZ == 0) begin : g_bad_clk
      $error("drive_volume_requester: CLOCK_SPEED_HZ must be nonzero with the watchdog enabled");
   end
   drive_req_watchdog #(.LIMIT(LIMIT)) u_wd (
      .clk     (clk),
      .resetn  (resetn),
      .load    (state_n != state && (state_n == REQ || state_n == RELEASE)),
      .expired (expired)
   );
`else
   assign expired = 1'b0;
`endif
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = CHECK;
         CHECK:   state_n = chk_st == ST_OK ? REQ : DONE;
         REQ:     if (volume.ack || expired) state_n = RELEASE;
         RELEASE: if (!volume.ack || expired) state_n = DONE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state          <= IDLE;
         up             <= 1'b0;
         to_flag        <= 1'b0;
         lat_write      <= 1'b0;
         lat_lba        <= '0;
         lat_cnt        <= '0;
         volume.active  <= 1'b0;
         volume.rd      <= 1'b0;
         volume.wr      <= 1'b0;
         volume.lba     <= '0;
         volume.blk_cnt <= '0;
         done           <= 1'b0;
         busy           <= 1'b0;
         status         <= ST_OK;
      end else begin
         state         <= state_n;
         up            <= 1'b1;
         volume.active <= enable;
         if (accept) begin
            lat_write <= req_write;
            lat_lba   <= req_lba;
            lat_cnt   <= req_blk_cnt;
            to_flag   <= 1'b0;
         end else if (state == REQ && expired && !volume.ack)
            to_flag <= 1'b1;
         // address is frozen before rd/wr rise and held through RELEASE
         if (state == CHECK && state_n == REQ) begin
            volume.lba     <= lat_lba;
            volume.blk_cnt <= lat_cnt;
         end
         volume.rd <= state_n == REQ && !lat_write;
         volume.wr <= state_n == REQ && lat_write;
         busy      <= state_n != IDLE;
         done      <= state_n == DONE;
         if (state_n == DONE)
            status <= state == CHECK ? chk_st : (to_flag || expired) ? ST_TIMEOUT : ST_OK;
      end
endmodule
